// File: rtl/phoneme_sched_pkg.sv
// Shared types and defaults for the phoneme scheduler: FSM encoding, phoneme width, sizing defaults.
package phoneme_sched_pkg;

  localparam int unsigned PHONEME_W           = 6;
  localparam int unsigned DEPTH_DEFAULT       = 16;
  localparam int unsigned ACK_TIMEOUT_DEFAULT = 8;

  typedef logic [PHONEME_W-1:0] phoneme_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/phoneme_scheduler_if.sv
// Host-side and speech-datapath-side signals of the phoneme scheduler.
interface phoneme_scheduler_if
  import phoneme_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) ();

  phoneme_t                 in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  phoneme_t                 chat_data;
  logic                     chat_write;
  logic                     chat_busy;
  logic [$clog2(DEPTH):0]   level;
  logic                     idle;
  logic                     timeout_err;

  // Environment side: host plus speech datapath
  modport master (
    output in_data, in_valid, flush, chat_busy,
    input  in_ready, chat_data, chat_write, level, idle, timeout_err
  );

  // Scheduler side
  modport slave (
    input  in_data, in_valid, flush, chat_busy,
    output in_ready, chat_data, chat_write, level, idle, timeout_err
  );

endinterface

// File: rtl/phoneme_fifo.sv
// Synchronous phoneme queue with flush; head is the oldest entry, read without a pop.
module phoneme_fifo
  import phoneme_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  phoneme_t               wr_data,
  output phoneme_t               head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  phoneme_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  // Flush overrides both operations in the same cycle
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/phoneme_scheduler.sv
// Queues host phonemes and feeds them one at a time to the speech datapath,
// waiting for busy to rise and fall around each write, with an ack timeout.
module phoneme_scheduler
  import phoneme_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  phoneme_scheduler_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  sched_state_e    state;
  sched_state_e    state_next;
  logic [TW-1:0]   tmo_cnt;
  logic            set_err;
  logic            in_ready;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  phoneme_t        head;
  logic [LW-1:0]   level;
  phoneme_t        chat_data;
  logic            chat_write;
  logic            timeout_err;

  assign in_ready = !full && !rst;
  assign push     = bus.in_valid && in_ready && !bus.flush;
  assign pop      = (state == ST_ISSUE);

  phoneme_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (bus.flush),
    .wr_data (bus.in_data),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Next state; a same-cycle push into an empty queue starts an issue immediately
  always_comb begin
    state_next = state;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.chat_busy && !bus.flush && (!empty || push)) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.chat_busy) begin
          state_next = ST_WAIT_DONE;
        end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
          state_next = ST_IDLE;
          set_err    = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.chat_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      chat_write  <= 1'b0;
      chat_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_next;
      chat_write <= (state_next == ST_ISSUE);
      // Head is captured on entry to ISSUE, bypassing the queue when it is empty
      if (state_next == ST_ISSUE) chat_data <= empty ? bus.in_data : head;
      if (set_err) timeout_err <= 1'b1;
      if (state == ST_WAIT_ACK && state_next == ST_WAIT_ACK) tmo_cnt <= tmo_cnt + TW'(1);
      else                                                   tmo_cnt <= '0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.level       = level;
  assign bus.chat_data   = chat_data;
  assign bus.chat_write  = chat_write;
  assign bus.timeout_err = timeout_err;
  assign bus.idle        = empty && (state == ST_IDLE) && !bus.chat_busy;

endmodule

// File: tb/tb_phoneme_scheduler.sv
// Directed bench for phoneme_scheduler: scoreboard of pushed phonemes checked against
// chat_write output, plus a bench-side speech datapath model driving chat_busy.
`timescale 1ns/1ps
module tb_phoneme_scheduler;
  import phoneme_sched_pkg::*;

  localparam int unsigned DEPTH       = 16;
  localparam int unsigned ACK_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phoneme_scheduler_if #(.DEPTH(DEPTH)) bus ();

  phoneme_scheduler #(
    .DEPTH       (DEPTH),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int       total    = 0;
  int       bad      = 0;
  int       n_writes = 0;
  int       w0       = 0;
  phoneme_t exp_q [$];
  int       lv_q  [$];

  logic man_busy   = 1'b0;
  logic resp_busy  = 1'b0;
  int   resp_en    = 0;
  int   resp_delay = 2;
  int   resp_hold  = 100;

  assign bus.chat_busy = man_busy | resp_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest accepted phoneme
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.chat_write === 1'b1) begin
      n_writes++;
      lv_q.push_back(int'(bus.level));
      check("busy_low_at_write", 32'(bus.chat_busy), 32'd0);
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("chat_data_order", 32'(bus.chat_data), 32'(exp_q.pop_front()));
    end
  end

  // Speech datapath model: busy rises resp_delay edges after a write, held resp_hold edges
  initial begin
    forever begin
      @(negedge clk);
      if (resp_en != 0 && bus.chat_write === 1'b1) begin
        repeat (resp_delay) @(posedge clk);
        #1 resp_busy = 1'b1;
        repeat (resp_hold) @(posedge clk);
        #1 resp_busy = 1'b0;
      end
    end
  end

  task automatic drive_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 6'(base + i);
      exp_q.push_back(6'(base + i));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (bus.idle !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.idle), 32'd1);
  endtask

  task automatic wait_write(input string tag, input int budget);
    int k = 0;
    while (bus.chat_write !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.chat_write), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_chat_write", 32'(bus.chat_write), 32'd0);
    check("rst_chat_data", 32'(bus.chat_data), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_idle", 32'(bus.idle), 32'd1);

    // Single phoneme, write in the cycle after the accepting edge
    resp_en = 1; resp_delay = 2; resp_hold = 100;
    w0 = n_writes;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h05;
    exp_q.push_back(6'h05);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("latency_write", 32'(bus.chat_write), 32'd1);
    check("latency_data", 32'(bus.chat_data), 32'h05);
    wait_idle("single_idle", 300);
    check("single_writes", 32'(n_writes - w0), 32'd1);
    check("single_level", 32'(bus.level), 32'd0);

    // Three queued phonemes issued in order, level seen at each write 3,2,1
    resp_hold = 5;
    lv_q.delete();
    w0 = n_writes;
    man_busy = 1'b1;
    drive_burst(3, 6);
    check("three_level", 32'(bus.level), 32'd3);
    man_busy = 1'b0;
    wait_idle("three_idle", 200);
    check("three_writes", 32'(n_writes - w0), 32'd3);
    if (lv_q.size() == 3) begin
      check("three_lv0", 32'(lv_q[0]), 32'd3);
      check("three_lv1", 32'(lv_q[1]), 32'd2);
      check("three_lv2", 32'(lv_q[2]), 32'd1);
    end
    check("three_lv_count", 32'(lv_q.size()), 32'd3);
    check("three_level_end", 32'(bus.level), 32'd0);

    // Fill to DEPTH across pointer wrap, refuse 17th, drain in order
    resp_delay = 1; resp_hold = 2;
    w0 = n_writes;
    man_busy = 1'b1;
    drive_burst(16, 8'h10);
    check("full_level", 32'(bus.level), 32'd16);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h3F;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("full_refuse_level", 32'(bus.level), 32'd16);
    man_busy = 1'b0;
    wait_idle("full_idle", 400);
    check("full_writes", 32'(n_writes - w0), 32'd16);
    check("full_sb_empty", 32'(exp_q.size()), 32'd0);

    // Flush during WAIT_DONE with a same-cycle push
    resp_delay = 1; resp_hold = 20;
    w0 = n_writes;
    drive_burst(5, 8'h20);
    check("flush_pre_level", 32'(bus.level), 32'd4);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'h2A;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_level", 32'(bus.level), 32'd0);
    exp_q.delete();
    wait_idle("flush_idle", 100);
    check("flush_writes", 32'(n_writes - w0), 32'd1);
    repeat (10) @(negedge clk);
    check("flush_no_more_writes", 32'(n_writes - w0), 32'd1);
    check("flush_level_end", 32'(bus.level), 32'd0);

    // No ack: timeout after ACK_TIMEOUT cycles, then next entry issues
    resp_en = 0;
    check("tmo_err_before", 32'(bus.timeout_err), 32'd0);
    w0 = n_writes;
    man_busy = 1'b1;
    drive_burst(2, 8'h11);
    man_busy = 1'b0;
    wait_write("tmo_first_write", 20);
    repeat (ACK_TIMEOUT) @(negedge clk);
    check("tmo_err_last_wait", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    check("tmo_err_set", 32'(bus.timeout_err), 32'd1);
    @(negedge clk);
    check("tmo_next_write", 32'(bus.chat_write), 32'd1);
    wait_idle("tmo_idle", 100);
    check("tmo_writes", 32'(n_writes - w0), 32'd2);
    check("tmo_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset during WAIT_ACK with 3 entries queued
    man_busy = 1'b1;
    drive_burst(4, 8'h31);
    man_busy = 1'b0;
    wait_write("rst_mid_write", 20);
    @(negedge clk);
    check("rst_mid_level_pre", 32'(bus.level), 32'd3);
    w0  = n_writes;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_level", 32'(bus.level), 32'd0);
    check("rst_mid_chat_write", 32'(bus.chat_write), 32'd0);
    check("rst_mid_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (20) @(negedge clk);
    check("rst_mid_no_writes", 32'(n_writes - w0), 32'd0);
    check("rst_mid_idle", 32'(bus.idle), 32'd1);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phoneme_scheduler.md
PHONEME_SCHEDULER -- requirements
Module: phoneme_scheduler

Interface
REQ-001 Parameter DEPTH, default 16: phoneme queue depth in entries; power of two, 4..64.
REQ-002 Parameter ACK_TIMEOUT, default 8: maximum cycles to wait for chat_busy to rise after a write.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  6  phoneme code from host.
REQ-006 in_valid  input  1  host offers in_data this cycle.
REQ-007 in_ready  output  1  scheduler accepts in_data this cycle.
REQ-008 flush  input  1  single-cycle request to discard all queued phonemes.
REQ-009 chat_data  output  6  phoneme code to speech datapath, valid while chat_write is high.
REQ-010 chat_write  output  1  single-cycle write strobe to speech datapath.
REQ-011 chat_busy  input  1  speech datapath is playing a phoneme.
REQ-012 level  output  clog2(DEPTH)+1  number of queued entries.
REQ-013 idle  output  1  queue empty, FSM in IDLE and chat_busy low.
REQ-014 timeout_err  output  1  sticky flag; set on an ACK_TIMEOUT expiry.

Function
REQ-015 Push on a rising edge when in_valid and in_ready are both high; in_ready = (level < DEPTH) and not rst.
REQ-016 Queue order is strict FIFO; pointers wrap modulo DEPTH with no gap or loss at wrap-around.
REQ-017 FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-018 IDLE -> ISSUE when level > 0 and chat_busy low; otherwise remain in IDLE.
REQ-019 In ISSUE, chat_write = 1 for exactly one cycle and chat_data = queue head; the head is popped at the end of that cycle; next state is WAIT_ACK.
REQ-020 WAIT_ACK -> WAIT_DONE on the first cycle chat_busy is high.
REQ-021 WAIT_ACK -> IDLE after ACK_TIMEOUT cycles without chat_busy; timeout_err is set on that transition.
REQ-022 WAIT_DONE -> IDLE on the first cycle chat_busy is low.
REQ-023 chat_write is a registered or state-decoded output with no combinational path from in_valid or chat_busy.
REQ-024 chat_data holds its last value outside ISSUE.
REQ-025 Latency: a phoneme pushed into an empty queue while in IDLE with chat_busy low gives chat_write in the cycle immediately after the accepting edge.
REQ-026 Simultaneous push and pop: level is unchanged and both operations take effect.
REQ-027 Push when full is refused (in_ready low) even if a pop occurs the same cycle.
REQ-028 flush: level and pointers are cleared at the next edge; flush wins over a same-cycle push, which is dropped.
REQ-029 flush does not abort an in-progress phoneme; the FSM continues its current state sequence.
REQ-030 A flush during ISSUE still issues the already-selected head.
REQ-031 timeout_err is cleared only by rst.
REQ-032 level never exceeds DEPTH and never underflows.

Reset
REQ-033 On rst high at a rising edge: FSM enters IDLE; level = 0; chat_write = 0; chat_data = 0; timeout_err = 0; in_ready = 0 during reset and 1 on the first cycle after.
REQ-034 rst mid-operation discards queue contents and any pending wait with no further chat_write; the speech datapath is not otherwise signalled.

Structure
REQ-035 Shared package phoneme_sched_pkg holds the FSM state encoding, the phoneme code width (6), and the DEPTH and ACK_TIMEOUT defaults.
REQ-036 The queue is a separate sub-module, phoneme_fifo: synchronous, with push, pop, flush, head, level and full/empty.
REQ-037 The FSM and the timeout counter stay in phoneme_scheduler.

Verification
REQ-038 Push 0x05 with chat_busy modelled 2 cycles after the write and held 100 cycles -> one chat_write with chat_data = 0x05 in the cycle after the push, and idle = 1 after chat_busy falls.
REQ-039 Push 0x06, 0x07, 0x08 back-to-back -> three chat_write pulses in order, each only after chat_busy has fallen for the previous phoneme; level counts 3, 2, 1, 0.
REQ-040 Push 16 entries with chat_busy held high -> in_ready = 0 at level 16, a 17th in_valid is not accepted; on release, all 16 entries are issued in order across pointer wrap-around.
REQ-041 Queue 5 entries, assert flush while in WAIT_DONE with a same-cycle push -> level = 0, the current phoneme completes, and no further chat_write occurs.
REQ-042 chat_busy never rises after a write -> after 8 cycles the FSM is in IDLE, timeout_err = 1, and the next queued entry is issued.
REQ-043 Assert rst during WAIT_ACK with 3 entries queued -> in the next cycle level = 0, chat_write = 0, timeout_err = 0, and in_ready = 1 one cycle after rst is released.
